pattern_recorder: RTL

PATTERN_RECORDER -- requirements
Module: pattern_recorder

---
 rtl/drum_pkg.sv | 6 +
 rtl/step_counter.sv | 16 +
 rtl/pattern_recorder.sv | 70 +++++++
 3 files changed

// File: rtl/drum_pkg.sv
// drum_pkg: shared state encoding and default sizes for the drum pattern recorder.
package drum_pkg;
  localparam int NTRK_DEF = 5;
  localparam int NSTEP_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, REC = 2'd2} state_t;
endpackage

// File: rtl/step_counter.sv
// step_counter: wrapping up-counter with enable and async active-high reset.
//   Clk, Reset : clock, asynchronous reset to 0
//   en         : advance by one; wraps naturally at 2**W
//   count      : current value
module step_counter #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) count <= '0;
    else if (en) count <= count + W'(1);
endmodule

// File: rtl/pattern_recorder.sv
// pattern_recorder: records one loop of per-track drum taps into a step pattern.
//   Clk, Reset        : clock, asynchronous active-high reset
//   step_en           : one-cycle pulse ending the current step
//   Arm, Clear        : request one recorded loop / erase all patterns
//   Overdub           : 1 = OR taps into the pattern, 0 = replace
//   tap               : per-track tap pulses
//   pattern           : NTRK rows of NSTEP bits, track t at [NSTEP*t +: NSTEP]
//   step              : current step index
//   armed, recording  : state flags; done pulses when a recorded loop ends
module pattern_recorder
  import drum_pkg::*;
#(
  parameter int NTRK = NTRK_DEF,
  parameter int NSTEP = NSTEP_DEF
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     step_en,
  input  logic                     Arm,
  input  logic                     Clear,
  input  logic                     Overdub,
  input  logic [NTRK-1:0]          tap,
  output logic [NTRK*NSTEP-1:0]    pattern,
  output logic [$clog2(NSTEP)-1:0] step,
  output logic                     armed,
  output logic                     recording,
  output logic                     done
);
  localparam int SW = $clog2(NSTEP);
  state_t state, state_nxt;
  logic [NTRK-1:0] pending, pending_nxt;
  logic last, commit, done_nxt;
  step_counter #(.W(SW)) u_step (.Clk(Clk), .Reset(Reset), .en(step_en), .count(step));
  // last: the step_en that closes the final step of the loop
  assign last = step_en && (step == SW'(NSTEP - 1));
  assign commit = (state == REC) && step_en;
  always_comb begin
    state_nxt = Clear ? IDLE :
                (state == IDLE && Arm) ? ARMED :
                (state == ARMED && last) ? REC :
                (state == REC && last) ? IDLE : state;
    done_nxt = !Clear && state == REC && last;
    // taps landing with step_en go straight into the commit, not into pending
    pending_nxt = (Clear || state != REC || step_en) ? '0 : pending | tap;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      pending <= '0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      pending <= pending_nxt;
      done <= done_nxt;
    end
  for (genvar t = 0; t < NTRK; t++) begin : g_trk
    logic [NSTEP-1:0] row, row_nxt;
    always_comb begin
      row_nxt = row;
      if (Clear) row_nxt = '0;
      else if (commit) row_nxt[step] = pending[t] | tap[t] | (Overdub & row[step]);
    end
    always_ff @(posedge Clk or posedge Reset)
      if (Reset) row <= '0;
      else row <= row_nxt;
    assign pattern[NSTEP*t +: NSTEP] = row;
  end
  assign armed = state == ARMED;
  assign recording = state == REC;
endmodule
